// File: rtl/op_pkg.sv
// Shared opcode constants and FSM state type for the operation-select path.
// Used by op_select_encoder and the 2-to-4 op decoder.
package op_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      HOLD    = 2'b01,
      RELEASE = 2'b10
   } state_t;

   // 2-to-4 decode: opcode to one-hot button position.
   function automatic logic [3:0] op_decode(input logic [1:0] op);
      logic [3:0] onehot;
      onehot = '0;
      onehot[op] = 1'b1;
      return onehot;
   endfunction

   // Inverse of op_decode; only meaningful for single-hot inputs.
   function automatic logic [1:0] op_encode(input logic [3:0] onehot);
      logic [1:0] op;
      case (onehot)
         4'b0010: op = OP_SUB;
         4'b0100: op = OP_AND;
         4'b1000: op = OP_OR;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter; stable updates once the
// synchronized vector has held for DB_CYCLES consecutive matching cycles.
module btn_debounce #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stable
);

   localparam logic [7:0] CNT_MAX  = 8'(DB_CYCLES);
   localparam logic [7:0] CNT_LOAD = 8'(DB_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;
   logic [7:0]       cnt;

   // stable is written only on the edge the counter reaches CNT_MAX; while
   // saturated sync2 cannot differ from it, so no further load is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         prev   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         prev  <= sync2;
         if (sync2 == prev) begin
            if (cnt != CNT_MAX) begin
               cnt <= cnt + 8'd1;
            end
            if (cnt == CNT_LOAD) begin
               stable <= sync2;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/op_select_encoder.sv
// Debounced one-hot button to 2-bit opcode encoder with a valid/ready
// handshake; one operation per press, multi-button presses flagged.
module op_select_encoder
   import op_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn,
   input  logic       op_ready,
   output logic [1:0] op_sel,
   output logic       op_valid,
   output logic       multi_err
);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] stable;
   logic       single_hot;
   logic       multi_hot;

   btn_debounce #(
      .WIDTH     (4),
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (btn),
      .stable (stable)
   );

   always_comb begin
      single_hot = (stable != '0) && ((stable & (stable - 4'd1)) == '0);
      multi_hot  = (stable != '0) && !single_hot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (single_hot) begin
               state_nxt = HOLD;
            end else if (multi_hot) begin
               state_nxt = RELEASE;
            end
         end
         HOLD: begin
            if (op_ready) begin
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (stable == '0) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      op_valid = (state == HOLD);
   end

   // op_sel and multi_err only change on the IDLE decision edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_sel    <= OP_ADD;
         multi_err <= 1'b0;
      end else if (state == IDLE) begin
         if (single_hot) begin
            op_sel    <= op_encode(stable);
            multi_err <= 1'b0;
         end else if (multi_hot) begin
            multi_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_op_select_encoder.sv
// Self-checking bench for op_select_encoder: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random presses.
module tb_op_select_encoder;

   localparam int unsigned DB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn = '0;
   logic       op_ready = 1'b0;
   logic [1:0] op_sel;
   logic       op_valid;
   logic       multi_err;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   op_select_encoder #(
      .DB_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn),
      .op_ready  (op_ready),
      .op_sel    (op_sel),
      .op_valid  (op_valid),
      .multi_err (multi_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: hist[k] is btn as sampled k+1 edges ago. A value becomes the
   // debounced vector once DB+1 consecutive samples, ending two edges back
   // (synchronizer delay), are identical.
   logic [3:0] hist [0:DB+1];
   logic [3:0] m_stable = '0;
   logic       m_valid  = 1'b0;
   logic [1:0] m_sel    = '0;
   logic       m_err    = 1'b0;
   bit         m_armed  = 1'b1;

   initial begin
      for (int i = 0; i <= DB + 1; i++) hist[i] = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i <= DB + 1; i++) hist[i] = '0;
            m_stable = '0;
            m_valid  = 1'b0;
            m_sel    = '0;
            m_err    = 1'b0;
            m_armed  = 1'b1;
         end else begin
            bit same;
            if (m_valid) begin
               if (op_ready) m_valid = 1'b0;
            end else if (m_armed) begin
               if (m_stable != 0) begin
                  m_armed = 1'b0;
                  if ($countones(m_stable) == 1) begin
                     m_valid = 1'b1;
                     m_err   = 1'b0;
                     for (int i = 0; i < 4; i++) if (m_stable[i]) m_sel = 2'(i);
                  end else begin
                     m_err = 1'b1;
                  end
               end
            end else if (m_stable == 0) begin
               m_armed = 1'b1;
            end
            same = 1'b1;
            for (int i = 2; i <= DB + 1; i++) if (hist[i] != hist[1]) same = 1'b0;
            if (same) m_stable = hist[1];
            for (int i = DB + 1; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = btn;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("cmp_op_valid", 32'(op_valid), 32'(m_valid));
            check("cmp_op_sel", 32'(op_sel), 32'(m_sel));
            check("cmp_multi_err", 32'(multi_err), 32'(m_err));
         end
      end
   end

   initial begin
      int nv;
      logic [1:0] seen;

      cycles(2);
      check("reset_valid", 32'(op_valid), 32'd0);
      check("reset_sel", 32'(op_sel), 32'd0);
      check("reset_err", 32'(multi_err), 32'd0);
      cycles(1);
      #2 rst_n = 1'b1;
      cmp_en = 1'b1;
      cycles(6);

      // Latency: held 0100 is valid after E7, not after E6.
      btn = 4'b0100;
      cycles(7);
      check("lat_not_yet_valid", 32'(op_valid), 32'd0);
      cycles(1);
      check("lat_valid", 32'(op_valid), 32'd1);
      check("lat_sel_and", 32'(op_sel), 32'd2);
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         check("hold_valid", 32'(op_valid), 32'd1);
         check("hold_sel", 32'(op_sel), 32'd2);
      end
      op_ready = 1'b1;
      cycles(1);
      check("ready_clears_valid", 32'(op_valid), 32'd0);
      op_ready = 1'b0;
      btn = '0;
      cycles(10);

      // Glitch of three cycles.
      btn = 4'b0010;
      cycles(3);
      btn = '0;
      for (int i = 0; i < 12; i++) begin
         cycles(1);
         check("glitch_no_valid", 32'(op_valid), 32'd0);
         check("glitch_no_err", 32'(multi_err), 32'd0);
      end

      // Multi-hot press then a clean add.
      btn = 4'b1001;
      cycles(10);
      check("multi_err_set", 32'(multi_err), 32'd1);
      check("multi_no_valid", 32'(op_valid), 32'd0);
      btn = '0;
      cycles(10);
      check("multi_err_sticky", 32'(multi_err), 32'd1);
      btn = 4'b0001;
      cycles(8);
      check("add_valid", 32'(op_valid), 32'd1);
      check("add_sel", 32'(op_sel), 32'd0);
      check("add_clears_err", 32'(multi_err), 32'd0);
      op_ready = 1'b1;
      cycles(1);
      op_ready = 1'b0;
      btn = '0;
      cycles(10);

      // op_ready held high: exactly one valid cycle per press.
      op_ready = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         btn = 4'b1000;
         nv = 0;
         seen = '0;
         for (int i = 0; i < 30; i++) begin
            cycles(1);
            if (op_valid === 1'b1) begin
               nv++;
               seen = op_sel;
            end
         end
         check("oneshot_count", 32'(nv), 32'd1);
         check("oneshot_sel_or", 32'(seen), 32'd3);
         btn = '0;
         cycles(10);
      end
      op_ready = 1'b0;

      // Reset during HOLD drops the pending op.
      btn = 4'b0100;
      cycles(9);
      check("pre_reset_valid", 32'(op_valid), 32'd1);
      btn = '0;
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_valid", 32'(op_valid), 32'd0);
      check("async_reset_sel", 32'(op_sel), 32'd0);
      check("async_reset_err", 32'(multi_err), 32'd0);
      cycles(3);
      #2 rst_n = 1'b1;
      nv = 0;
      for (int i = 0; i < 15; i++) begin
         cycles(1);
         if (op_valid !== 1'b0) nv++;
      end
      check("no_replay_after_reset", 32'(nv), 32'd0);

      // Button held through reset is a new press after release.
      btn = 4'b0010;
      cycles(1);
      #2 rst_n = 1'b0;
      cycles(3);
      #2 rst_n = 1'b1;
      cycles(8);
      check("held_through_reset_valid", 32'(op_valid), 32'd1);
      check("held_through_reset_sel", 32'(op_sel), 32'd1);
      op_ready = 1'b1;
      cycles(1);
      op_ready = 1'b0;
      btn = '0;
      cycles(10);

      // Random presses, glitches and multi-hot patterns.
      for (int seg = 0; seg < 300; seg++) begin
         int kind;
         int len;
         kind = $urandom_range(0, 3);
         case (kind)
            0:       btn = '0;
            3:       btn = 4'($urandom_range(0, 15));
            default: btn = 4'(1 << $urandom_range(0, 3));
         endcase
         len = $urandom_range(1, 10);
         for (int c = 0; c < len; c++) begin
            op_ready = ($urandom_range(0, 3) == 0);
            cycles(1);
         end
      end
      btn = '0;
      op_ready = 1'b0;
      cycles(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
